// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV32I funct3 width codes, access legality and store lane steering.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Unsigned widths exist only for loads; halfwords need even, words 4-byte alignment.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] off);
        logic [3:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (funct3)
            F3_B:    lanes = {4{data[7:0]}};
            F3_H:    lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/halfword from a bus word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_W:    data = rdata;
            F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one req/gnt/rvalid data-bus transaction per accepted request.
// Optional LSU_BUS_TIMEOUT_EN adds a REQ/WAIT watchdog that reports bus_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_in,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misaligned_err,
    output logic            bus_err,
    output logic [1:0]      dbg_state
);

    if (XLEN != 32) begin : g_xlen_check
        $error("load_store_unit supports only XLEN=32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("load_store_unit TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t      state_q;
    logic            req_ready_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [3:0]      mem_be_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            misaligned_err_q;
    logic [XLEN-1:0] wb_data_d;
    logic            legal_d;

    assign legal_d = access_legal(is_store, funct3, addr[1:0]);

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata  (mem_rdata),
        .off    (off_q),
        .funct3 (funct3_q),
        .data   (wb_data_d)
    );

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W    = (TMO_BITS > 8) ? TMO_BITS : 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             bus_err_q;
    logic             tmo_hit;

    // The counter holds the number of cycles already spent in the current state.
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            req_ready_q      <= 1'b1;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_be_q         <= '0;
            mem_wdata_q      <= '0;
            funct3_q         <= '0;
            off_q            <= '0;
            rd_q             <= '0;
            wb_valid_q       <= 1'b0;
            wb_rd_q          <= '0;
            wb_data_q        <= '0;
            misaligned_err_q <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
            tmo_cnt_q        <= '0;
            bus_err_q        <= 1'b0;
`endif
        end else begin
`ifdef LSU_BUS_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        funct3_q    <= funct3;
                        off_q       <= addr[1:0];
                        rd_q        <= rd_in;
                        if (legal_d) begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store;
                            mem_addr_q  <= {addr[XLEN-1:2], 2'b00};
                            mem_be_q    <= store_be(funct3, addr[1:0]);
                            mem_wdata_q <= store_lanes(funct3, store_data);
                        end else begin
                            state_q          <= RESP;
                            wb_valid_q       <= 1'b1;
                            wb_rd_q          <= '0;
                            wb_data_q        <= '0;
                            misaligned_err_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q    <= RESP;
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= '0;
                            wb_data_q  <= '0;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
`ifdef LSU_BUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        mem_req_q  <= 1'b0;
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= '0;
                        wb_data_q  <= '0;
                        bus_err_q  <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= wb_data_d;
                    end
`ifdef LSU_BUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= '0;
                        wb_data_q  <= '0;
                        bus_err_q  <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q          <= IDLE;
                    req_ready_q      <= 1'b1;
                    wb_valid_q       <= 1'b0;
                    wb_rd_q          <= '0;
                    wb_data_q        <= '0;
                    misaligned_err_q <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
                    bus_err_q        <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_be         = mem_be_q;
    assign mem_wdata      = mem_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign misaligned_err = misaligned_err_q;
    assign dbg_state      = state_q;
`ifdef LSU_BUS_TIMEOUT_EN
    assign bus_err        = bus_err_q;
`else
    assign bus_err        = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// transactions checked against an arithmetic model of the access rules.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned_err;
    logic        bus_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .is_store       (is_store),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .rd_in          (rd_in),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .misaligned_err (misaligned_err),
        .bus_err        (bus_err),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, legality, lane steering, load extension.
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
        bit known;
        known = (f3 <= 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
        return known && ((a % m_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned mask;
        mask = ((1 << m_size(f3)) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % m_size(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdat);
        longint v;
        longint span;
        span = longint'(1) << (8 * m_size(f3));
        v = (longint'(rdat) >> (8 * (a % 4))) % span;
        if (f3[2] == 1'b0 && m_size(f3) < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic randomize_req_inputs();
        is_store   = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
        rd_in      = 5'($urandom);
    endtask

    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd, input int gnt_dly,
                          input int rv_dly, input logic [31:0] rdat);
        bit legal;
        legal = m_legal(st, f3, a);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d; rd_in = rd;
        @(negedge clk);
        req_valid = 1'b0;
        randomize_req_inputs();
        check("ready_busy", 32'(req_ready), 32'd0);
        if (!legal) begin
            check("err_wb_valid", 32'(wb_valid), 32'd1);
            check("err_flag", 32'(misaligned_err), 32'd1);
            check("err_wb_rd", 32'(wb_rd), 32'd0);
            check("err_no_req", 32'(mem_req), 32'd0);
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                check("req_held", 32'(mem_req), 32'd1);
                check("req_we", 32'(mem_we), 32'(st));
                check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
                check("req_be", 32'(mem_be), 32'(st ? m_be(f3, a) : mem_be));
                if (st) check("req_wdata", mem_wdata, m_wdata(f3, d));
                check("req_no_wb", 32'(wb_valid), 32'd0);
                mem_gnt = (i == gnt_dly);
                @(negedge clk);
            end
            mem_gnt = 1'b0;
            check("req_dropped", 32'(mem_req), 32'd0);
            if (!st) begin
                for (int i = 0; i < rv_dly; i++) begin
                    check("wait_no_wb", 32'(wb_valid), 32'd0);
                    @(negedge clk);
                end
                mem_rvalid = 1'b1;
                mem_rdata  = rdat;
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            check("wb_valid", 32'(wb_valid), 32'd1);
            check("wb_rd", 32'(wb_rd), st ? 32'd0 : 32'(rd));
            check("wb_data", wb_data, st ? 32'd0 : m_load(f3, a, rdat));
            check("wb_no_err", 32'(misaligned_err), 32'd0);
            check("wb_no_bus_err", 32'(bus_err), 32'd0);
        end
        @(negedge clk);
        check("wb_pulse_end", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        is_store = 1'b0; funct3 = '0; addr = '0; store_data = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 5'd7, 0, 0, 32'h0);
        do_txn(1'b0, F3_B, 32'h203, 32'h0, 5'd3, 0, 0, 32'h80FF_1234);
        do_txn(1'b0, F3_BU, 32'h203, 32'h0, 5'd4, 1, 2, 32'h80FF_1234);
        do_txn(1'b1, F3_H, 32'h302, 32'h0000_ABCD, 5'd9, 3, 0, 32'h0);
        do_txn(1'b0, F3_W, 32'h401, 32'h0, 5'd5, 0, 0, 32'h0);
        do_txn(1'b0, F3_HU, 32'h40A, 32'h0, 5'd6, 0, 1, 32'h9876_5432);
        do_txn(1'b1, 3'd3, 32'h40C, 32'h1234_5678, 5'd8, 0, 0, 32'h0);
        do_txn(1'b0, 3'd6, 32'h410, 32'h0, 5'd8, 0, 0, 32'h0);

        // Reset while waiting for load data; a late rvalid must be ignored.
        check("abort_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h500; rd_in = 5'd12;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_req_drop", 32'(mem_req), 32'd0);
        check("abort_no_wb", 32'(wb_valid), 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        check("abort_ready_up", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rvalid_wb", 32'(wb_valid), 32'd0);
        check("late_rvalid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("late_rvalid_wb2", 32'(wb_valid), 32'd0);

        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   5'($urandom_range(1, 31)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), $urandom);
        end

`ifdef LSU_BUS_TIMEOUT_EN
        req_valid = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h600; rd_in = 5'd10;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_wait_no_wb", 32'(wb_valid), 32'd0);
            @(negedge clk);
        end
        check("tmo_wait_wb", 32'(wb_valid), 32'd1);
        check("tmo_wait_bus_err", 32'(bus_err), 32'd1);
        check("tmo_wait_rd", 32'(wb_rd), 32'd0);
        @(negedge clk);
        check("tmo_wait_clear", 32'(bus_err), 32'd0);
        req_valid = 1'b1; is_store = 1'b1; funct3 = F3_W; addr = 32'h604; rd_in = 5'd11;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_req_held", 32'(mem_req), 32'd1);
            @(negedge clk);
        end
        check("tmo_req_drop", 32'(mem_req), 32'd0);
        check("tmo_req_bus_err", 32'(bus_err), 32'd1);
        check("tmo_req_wb", 32'(wb_valid), 32'd1);
        @(negedge clk);
        check("tmo_req_idle", 32'(req_ready), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
